// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16x16 unsigned multiply / multiply-accumulate.
// The operands are split into four 8x8 partial products. Each pair is issued
// to an external registered 8x8 multiplier that has MLAT cycles of latency.
// The returned products are shifted and summed into a 32-bit result.
//
// Ports:
//   clock        system clock (rising edge)
//   reset        asynchronous, active-high reset
//   start        request an operation; sampled only while busy=0
//   acc          sampled with start: 1 = add the product to z, 0 = overwrite z
//   x, y         16-bit operands, sampled with start
//   ma, mb       8-bit operands driven to the 8x8 multiplier
//   mp           16-bit product returned by the 8x8 multiplier
//   busy         an operation is in progress
//   done         one-cycle pulse when z has been updated
//   z            32-bit result, held until the next completion
module mul16_seq #(
  parameter int unsigned MLAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        acc,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [7:0]  ma,
  output logic [7:0]  mb,
  input  logic [15:0] mp,
  output logic        busy,
  output logic        done,
  output logic [31:0] z
);

  // Tag layout: {valid, last, shift code}. Shift code 0/1/2 means <<0/<<8/<<16.
  localparam int unsigned TW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_n;
  logic [1:0]    idx_q, idx_n;
  logic [15:0]   x_q, y_q;
  logic [31:0]   accum_q;
  logic [TW-1:0] tag_in_q, tag_in_n;
  logic [TW-1:0] tag_pipe_q [MLAT];
  logic [TW-1:0] tag_out;
  logic [7:0]    ma_n, mb_n;
  logic          busy_n, done_n;
  logic          accept, complete;
  logic [31:0]   term, sum;

  // The tag leaving the pipe lines up with the product currently on mp.
  assign tag_out  = tag_pipe_q[MLAT-1];
  assign complete = tag_out[3] & tag_out[2];
  assign accept   = (state_q == IDLE) & start;

  // Align the returned partial product to its weight.
  always_comb begin
    term = 32'(mp);
    case (tag_out[1:0])
      2'd0:    term = 32'(mp);
      2'd1:    term = 32'(mp) << 8;
      default: term = 32'(mp) << 16;
    endcase
  end

  assign sum = accum_q + term;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = ISSUE;
      ISSUE:   if (idx_q == 2'd3) state_n = DRAIN;
      DRAIN:   if (complete) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and the issue tag.
  // idx_q names the pair currently on ma/mb; each cycle in ISSUE loads the next.
  always_comb begin
    ma_n     = '0;
    mb_n     = '0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    idx_n    = idx_q;
    tag_in_n = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ma_n     = x[7:0];
          mb_n     = y[7:0];
          busy_n   = 1'b1;
          idx_n    = 2'd0;
          tag_in_n = {1'b1, 1'b0, 2'd0};
        end
      end
      ISSUE: begin
        busy_n = 1'b1;
        idx_n  = idx_q + 2'd1;
        case (idx_q)
          2'd0: begin
            ma_n     = x_q[7:0];
            mb_n     = y_q[15:8];
            tag_in_n = {1'b1, 1'b0, 2'd1};
          end
          2'd1: begin
            ma_n     = x_q[15:8];
            mb_n     = y_q[7:0];
            tag_in_n = {1'b1, 1'b0, 2'd1};
          end
          2'd2: begin
            ma_n     = x_q[15:8];
            mb_n     = y_q[15:8];
            tag_in_n = {1'b1, 1'b1, 2'd2};
          end
          default: begin
            ma_n = '0;
            mb_n = '0;
          end
        endcase
      end
      DRAIN: begin
        busy_n = ~complete;
        done_n = complete;
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase
  end

  // Datapath registers: outputs, operand latches, tag pipe, accumulator, result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ma       <= '0;
      mb       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      z        <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      accum_q  <= '0;
      tag_in_q <= '0;
      for (int i = 0; i < int'(MLAT); i++) tag_pipe_q[i] <= '0;
    end else begin
      ma       <= ma_n;
      mb       <= mb_n;
      busy     <= busy_n;
      done     <= done_n;
      idx_q    <= idx_n;
      tag_in_q <= tag_in_n;
      tag_pipe_q[0] <= tag_in_q;
      for (int i = 1; i < int'(MLAT); i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
      if (accept) begin
        x_q     <= x;
        y_q     <= y;
        accum_q <= acc ? z : '0;
      end else if (tag_out[3]) begin
        accum_q <= sum;
      end
      // The last partial product is folded in on the same edge it updates z.
      if (complete) z <= sum;
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
module tb_mul16_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start1, start3, acc;
  logic [15:0] x, y;
  logic [7:0]  ma1, mb1, ma3, mb3;
  logic [15:0] mp1, mp3;
  logic        busy1, done1, busy3, done3;
  logic [31:0] z1, z3;
  logic [15:0] m3_pipe [3];

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] z1_model, z3_model;

  always #5 clock = ~clock;

  mul16_seq #(.MLAT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .acc(acc), .x(x), .y(y),
    .ma(ma1), .mb(mb1), .mp(mp1), .busy(busy1), .done(done1), .z(z1)
  );

  mul16_seq #(.MLAT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .acc(acc), .x(x), .y(y),
    .ma(ma3), .mb(mb3), .mp(mp3), .busy(busy3), .done(done3), .z(z3)
  );

  // Behavioural 8x8 multipliers with 1 and 3 cycles of latency.
  always @(posedge clock) mp1 <= 16'(ma1) * 16'(mb1);
  always @(posedge clock) begin
    m3_pipe[0] <= 16'(ma3) * 16'(mb3);
    m3_pipe[1] <= m3_pipe[0];
    m3_pipe[2] <= m3_pipe[1];
  end
  assign mp3 = m3_pipe[2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0; acc = 1'b0; x = '0; y = '0;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({ma1, mb1, busy1, done1, z1} !== 50'h0)
      $display("FAIL reset dut1 outputs: got %h want 0", {ma1, mb1, busy1, done1, z1});
    else n_pass++;
    n_total++;
    if ({ma3, mb3, busy3, done3, z3} !== 50'h0)
      $display("FAIL reset dut3 outputs: got %h want 0", {ma3, mb3, busy3, done3, z3});
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    z1_model = '0;
    z3_model = '0;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if ({ma1, mb1, busy1, done1, z1} !== 50'h0)
      $display("FAIL idle after reset: got %h want 0", {ma1, mb1, busy1, done1, z1});
    else n_pass++;
  endtask

  // One operation on the MLAT=1 instance, checked edge by edge from N to N+6.
  task automatic test_single_op(input string name, input logic [15:0] tx, input logic [15:0] ty,
                                input logic tacc);
    logic [7:0]  ea [4];
    logic [7:0]  eb [4];
    logic [31:0] prod, exp_z;
    logic [15:0] exp_ab;
    prod  = 32'(tx) * 32'(ty);
    exp_z = tacc ? z1_model + prod : prod;
    ea = '{tx[7:0], tx[7:0], tx[15:8], tx[15:8]};
    eb = '{ty[7:0], ty[15:8], ty[7:0], ty[15:8]};
    x = tx; y = ty; acc = tacc; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    x = 16'($urandom); y = 16'($urandom); acc = 1'($urandom);
    for (int i = 0; i <= 5; i++) begin
      exp_ab = (i < 4) ? {ea[i[1:0]], eb[i[1:0]]} : 16'h0;
      n_total++;
      if ({ma1, mb1} !== exp_ab)
        $display("FAIL %s ma/mb at N+%0d: got %h want %h", name, i, {ma1, mb1}, exp_ab);
      else n_pass++;
      n_total++;
      if ({busy1, done1} !== ((i < 5) ? 2'b10 : 2'b01))
        $display("FAIL %s busy/done at N+%0d: got %b want %b", name, i, {busy1, done1},
                 (i < 5) ? 2'b10 : 2'b01);
      else n_pass++;
      n_total++;
      if (z1 !== ((i < 5) ? z1_model : exp_z))
        $display("FAIL %s z at N+%0d: got %h want %h", name, i, z1, (i < 5) ? z1_model : exp_z);
      else n_pass++;
      if (i < 5) begin
        @(posedge clock); #1;
      end
    end
    z1_model = exp_z;
    @(posedge clock); #1;
    n_total++;
    if ({busy1, done1} !== 2'b00)
      $display("FAIL %s done not single-cycle: got busy/done %b want 00", name, {busy1, done1});
    else n_pass++;
  endtask

  // Same flow on the MLAT=3 instance: completion moves to N+7.
  task automatic test_mlat3(input string name, input logic [15:0] tx, input logic [15:0] ty);
    logic [7:0]  ea [4];
    logic [7:0]  eb [4];
    logic [31:0] exp_z;
    logic [15:0] exp_ab;
    exp_z = 32'(tx) * 32'(ty);
    ea = '{tx[7:0], tx[7:0], tx[15:8], tx[15:8]};
    eb = '{ty[7:0], ty[15:8], ty[7:0], ty[15:8]};
    x = tx; y = ty; acc = 1'b0; start3 = 1'b1;
    @(posedge clock); #1;
    start3 = 1'b0;
    x = 16'($urandom); y = 16'($urandom);
    for (int i = 0; i <= 7; i++) begin
      exp_ab = (i < 4) ? {ea[i[1:0]], eb[i[1:0]]} : 16'h0;
      n_total++;
      if ({ma3, mb3} !== exp_ab)
        $display("FAIL %s ma/mb at N+%0d: got %h want %h", name, i, {ma3, mb3}, exp_ab);
      else n_pass++;
      n_total++;
      if ({busy3, done3} !== ((i < 7) ? 2'b10 : 2'b01))
        $display("FAIL %s busy/done at N+%0d: got %b want %b", name, i, {busy3, done3},
                 (i < 7) ? 2'b10 : 2'b01);
      else n_pass++;
      if (i < 7) begin
        @(posedge clock); #1;
      end
    end
    n_total++;
    if (z3 !== exp_z) $display("FAIL %s z: got %h want %h", name, z3, exp_z);
    else n_pass++;
    z3_model = exp_z;
    @(posedge clock); #1;
    n_total++;
    if (z3 !== z3_model) $display("FAIL %s z hold: got %h want %h", name, z3, z3_model);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    x = 16'h0002; y = 16'h0003; acc = 1'b0; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    @(posedge clock); #1;
    start1 = 1'b1; x = 16'hFFFF; y = 16'hFFFF; acc = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    for (int e = 3; e <= 12; e++) begin
      @(posedge clock); #1;
      if (done1) dones++;
      if (e == 5) begin
        n_total++;
        if (z1 !== 32'h6 || done1 !== 1'b1)
          $display("FAIL ignore_start z/done at N+5: got %h/%b want 00000006/1", z1, done1);
        else n_pass++;
      end
    end
    n_total++;
    if (dones != 1) $display("FAIL ignore_start done pulses: got %0d want 1", dones);
    else n_pass++;
    z1_model = 32'h6;
  endtask

  task automatic test_reset_abort();
    x = 16'hFFFF; y = 16'hFFFF; acc = 1'b0; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_total++;
    if ({busy1, done1} !== 2'b00) $display("FAIL abort busy/done: got %b want 00", {busy1, done1});
    else n_pass++;
    n_total++;
    if ({ma1, mb1} !== 16'h0) $display("FAIL abort ma/mb: got %h want 0000", {ma1, mb1});
    else n_pass++;
    n_total++;
    if (z1 !== 32'h0) $display("FAIL abort z: got %h want 00000000", z1);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    z1_model = '0;
    z3_model = '0;
    repeat (6) @(posedge clock);
    #1;
    n_total++;
    if ({busy1, done1, z1} !== 34'h0)
      $display("FAIL abort leftover activity: got %h want 0", {busy1, done1, z1});
    else n_pass++;
    test_single_op("after_reset", 16'h0003, 16'h0005, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] tx1, ty1, tx2, ty2;
    logic [31:0] exp1, exp2;
    tx1 = 16'($urandom); ty1 = 16'($urandom);
    tx2 = 16'($urandom); ty2 = 16'($urandom);
    exp1 = 32'(tx1) * 32'(ty1);
    exp2 = exp1 + 32'(tx2) * 32'(ty2);
    x = tx1; y = ty1; acc = 1'b0; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      @(posedge clock); #1;
      if (e == 4) begin
        x = tx2; y = ty2; acc = 1'b1; start1 = 1'b1;
      end
      if (e == 5) begin
        n_total++;
        if ({busy1, done1} !== 2'b01 || z1 !== exp1)
          $display("FAIL b2b first done: got %b/%h want 01/%h", {busy1, done1}, z1, exp1);
        else n_pass++;
      end
      if (e == 6) begin
        start1 = 1'b0;
        n_total++;
        if ({busy1, done1} !== 2'b10 || {ma1, mb1} !== {tx2[7:0], ty2[7:0]})
          $display("FAIL b2b accept at N+6: got %b/%h want 10/%h", {busy1, done1}, {ma1, mb1},
                   {tx2[7:0], ty2[7:0]});
        else n_pass++;
      end
      if (e == 10) begin
        n_total++;
        if ({busy1, done1} !== 2'b10)
          $display("FAIL b2b busy at N+10: got %b want 10", {busy1, done1});
        else n_pass++;
      end
      if (e == 11) begin
        n_total++;
        if ({busy1, done1} !== 2'b01 || z1 !== exp2)
          $display("FAIL b2b second done: got %b/%h want 01/%h", {busy1, done1}, z1, exp2);
        else n_pass++;
      end
    end
    z1_model = exp2;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++)
      test_single_op("random", 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_single_op("ffff_x_ffff", 16'hFFFF, 16'hFFFF, 1'b0);
    test_single_op("acc_add", 16'h0001, 16'hFFFF, 1'b1);
    test_single_op("acc_wrap", 16'h0100, 16'h0100, 1'b1);
    test_single_op("x1234_y5678", 16'h1234, 16'h5678, 1'b0);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_mlat3("mlat3_ffff", 16'hFFFF, 16'hFFFF);
    test_mlat3("mlat3_1234", 16'h1234, 16'h5678);
    for (int k = 0; k < 4; k++) test_mlat3("mlat3_random", 16'($urandom), 16'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Sequential 16x16 unsigned multiply(-accumulate) controller built around the team's registered 8x8 multiplier.
- Sits both upstream and downstream of the 8x8 multiplier: it splits 16-bit operands into four 8x8 partial products, issues them on MA/MB, and consumes the returned 16-bit products on MP. It shifts and sums them into a 32-bit result.
- Exposes a start/busy/done handshake to the CPU datapath.

Parameters:
- MLAT, 1, latency in clock cycles of the external 8x8 multiplier: MP holds MA*MB of the operands presented MLAT rising edges earlier. Legal range is 1..4.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request a new operation; sampled only while BUSY=0.
- ACC  in  1  sampled with START; 1 = add the product to the current Z, 0 = overwrite Z.
- X  in  16  multiplicand; sampled with START.
- Y  in  16  multiplier; sampled with START.
- MA  out  8  operand A to the 8x8 multiplier.
- MB  out  8  operand B to the 8x8 multiplier.
- MP  in  16  product returned by the 8x8 multiplier.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse; Z is updated and valid.
- Z  out  32  result; held until the next completion.

Behaviour:
- Interface: one clock, CLOCK; reset is asynchronous and active-high, RESET.
- Reset values: state=IDLE, MA=0, MB=0, BUSY=0, DONE=0, Z=0, accumulator=0, issue index=0, valid pipe all 0.
- Reset asserted mid-operation aborts the operation immediately; no partial result reaches Z.
- Accept: at a rising edge N where START=1 and BUSY=0:
  - latch X, Y and ACC;
  - initialise the accumulator to Z if ACC=1, else 0;
  - go to ISSUE with idx=0; BUSY=1 from edge N.
- START while BUSY=1 is ignored. Changes on X/Y/ACC after acceptance have no effect.
- ISSUE: one partial product per cycle, idx 0..3, driven on MA/MB from registers.
  - idx0: MA=XL, MB=YL, shift 0.
  - idx1: MA=XL, MB=YH, shift 8.
  - idx2: MA=XH, MB=YL, shift 8.
  - idx3: MA=XH, MB=YH, shift 16.
  - XL/XH are X[7:0]/X[15:8]; YL/YH likewise.
  - Pair idx is presented during the cycle after edge N+idx.
- A valid/shift tag pipeline of depth MLAT tracks each issued pair. When the tag emerges, the accumulator adds (MP zero-extended to 32 bits) << shift at that edge.
- After idx3 issues: MA/MB return to 0 and state=DRAIN until the last tag is accumulated.
- Completion at edge N+4+MLAT (N+5 for default MLAT=1):
  - Z ← final accumulator sum;
  - DONE=1 for exactly one cycle;
  - BUSY=0;
  - state=IDLE.
- Arithmetic: all sums modulo 2^32. ACC=1 results wrap silently with no carry flag. With ACC=0 the result is the exact 32-bit product, so no overflow is possible.
- Back-to-back: START high during the DONE cycle is accepted at the next edge. Throughput is one operation per 4+MLAT+1 cycles.
- Z changes only at a completion edge or on reset.
- DONE and BUSY are never high in the same cycle.

Test Plan:
- Reset, then X=0xFFFF, Y=0xFFFF, ACC=0, START at edge N:
  - BUSY=1 during N..N+4;
  - MA/MB sequence is FF/FF, FF/FF, FF/FF, FF/FF;
  - DONE=1 only in the cycle after N+5, with Z=0xFFFE0001.
- X=0x1234, Y=0x5678, ACC=0:
  - MA/MB sequence is 34/78, 34/56, 12/78, 12/56;
  - Z=0x06260060 at N+5.
- Following test 1, X=0x0001, Y=0xFFFF, ACC=1 → Z=0xFFFF0000.
  - Then X=0x0100, Y=0x0100, ACC=1 → Z=0x00000000 (wrap).
- START at N with X=0x0002, Y=0x0003; at N+2 pulse START with X=0xFFFF, Y=0xFFFF:
  - the second request is ignored;
  - Z=0x00000006 at N+5;
  - exactly one DONE pulse.
- START at N (X=0xFFFF, Y=0xFFFF), assert RESET asynchronously between N+2 and N+3:
  - BUSY, DONE, Z, MA and MB are 0 immediately;
  - after release, X=0x0003, Y=0x0005 → Z=0x0000000F five edges after acceptance.
- Back-to-back: second START held high through the DONE cycle of an operation completing at N+5:
  - accepted at N+6;
  - second DONE at N+11.
- Repeat tests 1–2 with MLAT=3 and a matching delayed multiplier model → DONE at N+7.
